// File: rtl/axi_rd_port_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among NumPorts refill requesters.
// One burst in flight at a time; return beats are steered to the owner and length-checked.
module axi_rd_port_arbiter #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 64,
    parameter int BlenWidth = 2,
    parameter int IdWidth   = 4,
    parameter int DataWidth = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic [NumPorts-1:0]            req_i,
    output logic [NumPorts-1:0]            gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts*BlenWidth-1:0]  blen_i,
    input  logic [NumPorts*2-1:0]          size_i,
    input  logic [NumPorts*IdWidth-1:0]    id_i,
    input  logic [NumPorts-1:0]            rdy_i,
    output logic [NumPorts-1:0]            valid_o,
    output logic                           last_o,
    output logic [DataWidth-1:0]           data_o,
    output logic                           exokay_o,
    output logic                           rd_req_o,
    input  logic                           rd_gnt_i,
    output logic [AddrWidth-1:0]           rd_addr_o,
    output logic [BlenWidth-1:0]           rd_blen_o,
    output logic [1:0]                     rd_size_o,
    output logic [IdWidth-1:0]             rd_id_o,
    output logic                           rd_rdy_o,
    input  logic                           rd_valid_i,
    input  logic                           rd_last_i,
    input  logic [DataWidth-1:0]           rd_data_i,
    input  logic                           rd_exokay_i,
    output logic                           busy_o,
    output logic                           proto_err_o
);

    localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [PtrW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [PtrW-1:0]       r_sel_q, w_sel_q_nxt;
    logic [PtrW-1:0]       w_rr_sel, w_sel;
    logic [BlenWidth-1:0]  r_blen_q, w_blen_sel;
    logic [BlenWidth:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic                  r_proto_err, w_proto_err_nxt;
    logic                  w_any_req, w_beat, w_capture_blen;

    // First requesting port at or above ptr, wrapping around.
    function automatic logic [PtrW-1:0] rr_pick(input logic [NumPorts-1:0] req,
                                                input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (req[idx]) pick = PtrW'(idx);
        end
        return pick;
    endfunction

    assign w_any_req  = |req_i;
    assign w_rr_sel   = rr_pick(req_i, r_rr_ptr);
    assign w_sel      = (r_state == IDLE) ? w_rr_sel : r_sel_q;
    assign w_blen_sel = blen_i[int'(w_sel)*BlenWidth +: BlenWidth];

    // Channel fields are zeroed whenever no request is being presented.
    assign rd_addr_o = rd_req_o ? addr_i[int'(w_sel)*AddrWidth +: AddrWidth] : '0;
    assign rd_blen_o = rd_req_o ? w_blen_sel : '0;
    assign rd_size_o = rd_req_o ? size_i[int'(w_sel)*2 +: 2] : '0;
    assign rd_id_o   = rd_req_o ? id_i[int'(w_sel)*IdWidth +: IdWidth] : '0;

    assign data_o      = rd_data_i;
    assign busy_o      = (r_state != IDLE);
    assign proto_err_o = r_proto_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_q_nxt     = r_sel_q;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_proto_err_nxt = r_proto_err;
        w_capture_blen  = 1'b0;
        w_beat          = 1'b0;
        gnt_o           = '0;
        valid_o         = '0;
        rd_req_o        = 1'b0;
        rd_rdy_o        = 1'b0;
        last_o          = 1'b0;
        exokay_o        = 1'b0;
        case (r_state)
            IDLE: begin
                rd_req_o = w_any_req;
                if (w_any_req) begin
                    w_sel_q_nxt = w_sel;
                    if (rd_gnt_i) begin
                        gnt_o[w_sel]   = 1'b1;
                        w_capture_blen = 1'b1;
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = DATA;
                    end else begin
                        w_state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                // Request stays up even if the requester withdraws: AXI forbids retracting it.
                rd_req_o = 1'b1;
                if (rd_gnt_i) begin
                    gnt_o[r_sel_q] = 1'b1;
                    w_capture_blen = 1'b1;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = DATA;
                end
            end
            DATA: begin
                rd_rdy_o         = rdy_i[r_sel_q];
                valid_o[r_sel_q] = rd_valid_i;
                last_o           = rd_last_i;
                exokay_o         = rd_exokay_i;
                w_beat           = rd_valid_i & rd_rdy_o;
                if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (rd_last_i ? (r_beat_cnt != {1'b0, r_blen_q})
                                  : (r_beat_cnt == {1'b0, r_blen_q})) begin
                        w_proto_err_nxt = 1'b1;
                    end
                    if (rd_last_i) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = (r_sel_q == PtrW'(NumPorts - 1)) ? '0 : r_sel_q + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_sel_q     <= '0;
            r_beat_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_sel_q     <= w_sel_q_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    // Burst length is pure data; it is always reloaded at grant before use.
    always_ff @(posedge clk_i) begin
        if (w_capture_blen) r_blen_q <= w_blen_sel;
    end

endmodule

// File: doc/axi_rd_port_arbiter.md
Name: axi_rd_port_arbiter

Overview:
- Shares the single read channel of one `axi_shim` between NumPorts refill requesters, e.g. the L1I$ wrapper and an uncached fetch/PTW path.
- Round-robin arbitration, one outstanding burst at a time.
- Return beats are routed back to the owning requester.
- Beat counting checks each returned burst against the granted burst length.

Parameters:
- NumPorts, 2, number of requesters (≥2)
- AddrWidth, 64, read address width
- BlenWidth, 2, burst length field width (beats = blen+1)
- IdWidth, 4, AXI ID width
- DataWidth, 64, read data width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clr_i  in  1  synchronous clear, same effect as reset
- req_i  in  NumPorts  per-port read request
- gnt_o  out  NumPorts  per-port grant, one-hot or zero
- addr_i  in  NumPorts×AddrWidth  per-port address
- blen_i  in  NumPorts×BlenWidth  per-port burst length
- size_i  in  NumPorts×2  per-port beat size
- id_i  in  NumPorts×IdWidth  per-port ID
- rdy_i  in  NumPorts  per-port ready for return beats
- valid_o  out  NumPorts  per-port return beat valid
- last_o  out  1  return last, broadcast
- data_o  out  DataWidth  return data, broadcast
- exokay_o  out  1  return exokay, broadcast
- rd_req_o  out  1  to shim rd_req_i
- rd_gnt_i  in  1  from shim rd_gnt_o
- rd_addr_o  out  AddrWidth  to shim
- rd_blen_o  out  BlenWidth  to shim
- rd_size_o  out  2  to shim
- rd_id_o  out  IdWidth  to shim
- rd_rdy_o  out  1  to shim
- rd_valid_i  in  1  from shim
- rd_last_i  in  1  from shim
- rd_data_i  in  DataWidth  from shim
- rd_exokay_i  in  1  from shim
- busy_o  out  1  state ≠ IDLE
- proto_err_o  out  1  sticky burst-length mismatch

Behaviour:
- **Reset / clear.** rst_ni low or clr_i high at a clock edge forces:
  - state = IDLE, rr_ptr = 0, sel_q = 0, beat_cnt = 0, proto_err_o = 0.
  - This applies mid-burst as well; the in-flight burst is abandoned and remaining beats are not forwarded.
- **Outputs with registered state at reset values:** all outputs except data_o are 0 (rd_rdy_o = 0, busy_o = 0). data_o follows rd_data_i combinationally and is don't-care.
- **States:** IDLE, ADDR, DATA.
- **IDLE**
  - sel = first index with req_i set, searching upward from rr_ptr with wrap.
  - rd_req_o = |req_i; rd_addr/blen/size/id_o are driven from port sel.
  - rd_gnt_i=1: gnt_o[sel]=1 in the same cycle (zero-latency pass-through); capture sel_q and blen_q; beat_cnt=0; go to DATA.
  - rd_gnt_i=0 with a request present: capture sel_q; go to ADDR.
- **ADDR**
  - Selection is locked to sel_q; rd_req_o=1 and channel fields come from port sel_q.
  - Requesters hold req_i and fields stable until granted.
  - rd_gnt_i=1: gnt_o[sel_q]=1, capture blen_q, beat_cnt=0, go to DATA.
  - If req_i[sel_q] drops before grant, rd_req_o stays asserted; AXI forbids withdrawing a request.
- **DATA**
  - rd_req_o=0; no other grants are issued.
  - rd_rdy_o = rdy_i[sel_q].
  - valid_o[sel_q] = rd_valid_i; valid_o of all other ports is 0.
  - last_o, exokay_o pass through from the shim.
  - A beat is accepted when rd_valid_i & rd_rdy_o; beat_cnt increments (width BlenWidth+1, no wrap within a legal burst).
  - On an accepted beat with rd_last_i: return to IDLE next cycle and set rr_ptr = (sel_q+1) mod NumPorts.
- **Latency:** earliest new grant is the cycle after the last beat.
- **Burst check** (proto_err_o sets on either condition, stays set until reset/clr):
  - Accepted last beat with beat_cnt ≠ blen_q.
  - Accepted non-last beat with beat_cnt == blen_q.
  - The FSM still returns to IDLE only on rd_last_i.
- **Routing outside DATA:** rd_valid_i is ignored (rd_rdy_o=0 in IDLE/ADDR).
- **Arbitration fairness:** a requester waits at most NumPorts−1 bursts.
- **Single-port case:** with only one port requesting, it is granted repeatedly with no idle penalty beyond the post-last cycle.

Test Plan:
- Single request: port0 req, addr 0x8000_0040, blen 3, rd_gnt_i same cycle → gnt_o=01 that cycle. Four beats 0xA0..0xA3 on valid_o[0], last_o on 4th. busy_o deasserts next cycle. proto_err_o=0.
- Contention: req_i=11 from reset → port0 granted first. Port1 is granted in the cycle after port0's last beat. Then with req_i=11 again → port0 (rr_ptr wrapped).
- Grant backpressure: port1 req, rd_gnt_i held 0 for 3 cycles while port0 also asserts → rd_addr_o stays port1's address, rd_id_o stays port1's ID, gnt_o[1] when rd_gnt_i=1. Port0 is never granted during this.
- Return backpressure: blen 1, rdy_i[0] toggles 0/1 → rd_rdy_o mirrors rdy_i[0], exactly 2 beats accepted, valid_o[1] never high.
- Length error: blen 3 granted, shim asserts rd_last_i on 2nd beat → proto_err_o=1 from next cycle and remains 1 after later good bursts. FSM returns to IDLE.
- Reset mid-burst: rst_ni low for 1 cycle after beat 1 of 4 → next cycle state IDLE, all outputs except data_o 0, rr_ptr=0. Remaining shim beats are not forwarded (rd_rdy_o=0, valid_o=0). A subsequent request is granted normally.
